// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable serial pattern detector:
//   - state_t     : controller FSM states (IDLE / RUN / DONE)
//   - DEF_*       : configuration loaded by reset (pattern 10110, len 5,
//                   target 0 = run forever)
//   - len_w()     : width needed to hold a length value 0..max_len
// Optional build macro used by the detector: SEQ_DET_NO_OVERLAP_EN
// (see seq_match_core).
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] DEF_PATTERN = 5'b10110;
  localparam int         DEF_LEN     = 5;
  localparam int         DEF_TARGET  = 0;

  // Bits needed to represent every value 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// -----------------------------------------------------------------------------
// seq_match_core
// Serial matcher: history shift register, bit-fill counter and a
// length-masked compare against the programmed pattern.
//
// Build option: SEQ_DET_NO_OVERLAP_EN
//   defined   - history and fill are cleared when a match registers, so the
//               bits of one match are never reused by the next one.
//   undefined - overlapping matches are detected.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of history, fill and match
//   shift_en   : din is a valid bit this cycle
//   din        : serial data bit (shifted into history LSB)
//   pattern    : pattern; bit [len-1] is the first bit received
//   len        : active pattern length in bits
//   match      : one-cycle pulse, registered on the edge that samples the
//                completing bit
// -----------------------------------------------------------------------------
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_match;

  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_nxt;
  logic               w_hit;

  // The compare looks at the history as it will be after this edge, so the
  // match register goes high on the same edge that samples the last bit.
  always_comb begin
    w_hist_nxt = {r_hist[MAX_LEN-2:0], din};
    w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len));
    end
    w_hit = shift_en && (w_fill_nxt >= len) &&
            (((w_hist_nxt ^ pattern) & w_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (clr) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (shift_en) begin
`ifdef SEQ_DET_NO_OVERLAP_EN
        if (w_hit) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_hist_nxt;
          r_fill <= w_fill_nxt;
        end
`else
        r_hist <= w_hist_nxt;
        r_fill <= w_fill_nxt;
`endif
      end
    end
  end

  assign match = r_match;

endmodule

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Run-time controller for the serial pattern detector. Holds the programmed
// pattern / length / match target, sequences IDLE -> RUN -> DONE, counts
// matches (saturating) and stretches each hit into a PULSE_W-cycle pulse.
//
// Build option: SEQ_DET_NO_OVERLAP_EN (handled inside seq_match_core).
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_valid    : config write strobe, accepted when cfg_ready is high
//   cfg_ready    : high in IDLE and DONE
//   cfg_pattern  : pattern; bit [cfg_len-1] is the first bit received
//   cfg_len      : pattern length (1..MAX_LEN is startable)
//   cfg_target   : matches before DONE; 0 = run forever
//   start        : begin detection (ignored in RUN)
//   abort        : return to IDLE; wins over start
//   din_valid    : din qualifier
//   din          : serial data bit
//   hit_pulse    : stretched match indication
//   match_cnt    : matches since last start, saturating
//   busy / done  : high in RUN / DONE
// -----------------------------------------------------------------------------
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [len_w(MAX_LEN)-1:0]    cfg_len,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         din_valid,
  input  logic                         din,
  output logic                         hit_pulse,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = len_w(MAX_LEN);
  localparam int STR_W = $clog2(PULSE_W + 1);

  localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(MAX_LEN);
  localparam logic [STR_W-1:0]   STR_LOAD    = STR_W'(PULSE_W);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_PATTERN);
  localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0]   RST_TARGET  = CNT_W'(DEF_TARGET);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_cnt;
  logic [STR_W-1:0]   r_stretch;

  logic               w_len_ok;
  logic               w_reached;
  logic               w_enter_run;
  logic               w_shift_en;
  logic               w_core_match;
  logic               w_take;

  assign w_len_ok  = (r_len != '0) && (r_len <= LEN_MAX);
  assign w_reached = (r_target != '0) && (r_cnt == r_target);

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    cfg_ready   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!abort && start && w_len_ok) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        cfg_ready = 1'b0;
        if (abort)          w_state_nxt = ST_IDLE;
        else if (w_reached) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (abort)                  w_state_nxt = ST_IDLE;
        else if (start && w_len_ok) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Clearing happens on every entry into RUN, from IDLE or from DONE.
  assign w_enter_run = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
  assign w_shift_en  = (r_state == ST_RUN) && din_valid;
  // A match is only acted on while running; abort suppresses it so the
  // count is held and the pulse is forced low.
  assign w_take      = (r_state == ST_RUN) && w_core_match && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern <= RST_PATTERN;
      r_len     <= RST_LEN;
      r_target  <= RST_TARGET;
    end else if (cfg_valid && cfg_ready) begin
      r_pattern <= cfg_pattern;
      r_len     <= cfg_len;
      r_target  <= cfg_target;
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_enter_run),
    .shift_en (w_shift_en),
    .din      (din),
    .pattern  (r_pattern),
    .len      (r_len),
    .match    (w_core_match)
  );

  // Once the target is reached the count freezes, even for a match that
  // lands on the edge taking the FSM into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_enter_run) begin
      r_cnt <= '0;
    end else if (w_take && !w_reached && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stretcher: a new match reloads the full width, so back-to-back hits
  // give one continuous pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stretch <= '0;
    end else if (w_enter_run || abort) begin
      r_stretch <= '0;
    end else if (w_take) begin
      r_stretch <= STR_LOAD;
    end else if (r_stretch != '0) begin
      r_stretch <= r_stretch - 1'b1;
    end
  end

  assign hit_pulse = (r_stretch != '0);
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int PULSE_W = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               hit_pulse;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W),
    .PULSE_W (PULSE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .din_valid   (din_valid),
    .din         (din),
    .hit_pulse   (hit_pulse),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 running, 2 finished. Received bits are kept as a list;
  // a match is "the newest len bits spell the pattern".
  int m_mode;
  bit m_bits[$];
  int m_cnt;
  bit m_pend;
  int m_edge;
  int m_pulse_end;
  int m_pat, m_len, m_tgt;
  bit mchk = 1'b0;

  task automatic model_reset();
    m_mode = 0;
    m_bits.delete();
    m_cnt = 0;
    m_pend = 1'b0;
    m_edge = 0;
    m_pulse_end = 0;
    m_pat = 'b10110;
    m_len = 5;
    m_tgt = 0;
  endtask

  task automatic model_edge();
    int  old;
    bit  reached, take, enter, lok;
    int  v;
    old     = m_mode;
    reached = (m_tgt != 0) && (m_cnt == m_tgt);
    take    = (old == 1) && m_pend && !abort;
    lok     = (m_len >= 1) && (m_len <= MAX_LEN);
    m_edge++;
    if (old == 0) begin
      if (!abort && start && lok) m_mode = 1;
    end else if (old == 1) begin
      if (abort) m_mode = 0;
      else if (reached) m_mode = 2;
    end else begin
      if (abort) m_mode = 0;
      else if (start && lok) m_mode = 1;
    end
    enter = (m_mode == 1) && (old != 1);
    if (enter) begin
      m_cnt = 0;
      m_pulse_end = m_edge;
    end else begin
      if (take && !reached && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (abort) m_pulse_end = m_edge;
      else if (take) m_pulse_end = m_edge + PULSE_W;
    end
    m_pend = 1'b0;
    if (enter) begin
      m_bits.delete();
    end else if (old == 1 && din_valid) begin
      m_bits.push_back(din);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        v = 0;
        for (int i = m_bits.size() - m_len; i < m_bits.size(); i++) v = (v << 1) | int'(m_bits[i]);
        if (v == (m_pat & ((1 << m_len) - 1))) begin
          m_pend = 1'b1;
`ifdef SEQ_DET_NO_OVERLAP_EN
          m_bits.delete();
`endif
        end
      end
    end
    if (old != 1 && cfg_valid) begin
      m_pat = int'(cfg_pattern);
      m_len = int'(cfg_len);
      m_tgt = int'(cfg_target);
    end
  endtask

  task automatic model_chk();
    chk("mdl_hit", hit_pulse, (m_edge < m_pulse_end) ? 1 : 0);
    chk("mdl_cnt", match_cnt, m_cnt);
    chk("mdl_busy", busy, (m_mode == 1) ? 1 : 0);
    chk("mdl_done", done, (m_mode == 2) ? 1 : 0);
    chk("mdl_rdy", cfg_ready, (m_mode != 1) ? 1 : 0);
  endtask

  // ---------------- drive helpers ----------------
  task automatic drive(input logic cv, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic [CNT_W-1:0] tgt, input logic st, input logic ab,
                       input logic dv, input logic d);
    cfg_valid = cv; cfg_pattern = pat; cfg_len = len; cfg_target = tgt;
    start = st; abort = ab; din_valid = dv; din = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (mchk) model_chk();
  endtask

  task automatic idle();                 drive(0, 0, 0, 0, 0, 0, 0, 0); step(); endtask
  task automatic bit_in(input logic dv, input logic d); drive(0, 0, 0, 0, 0, 0, dv, d); step(); endtask
  task automatic do_start();             drive(0, 0, 0, 0, 1, 0, 0, 0); step(); endtask
  task automatic do_abort();             drive(0, 0, 0, 0, 0, 1, 0, 0); step(); endtask
  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] t);
    drive(1, p, l, t, 0, 0, 0, 0); step();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic             cv;
    logic [7:0]       pat;
    logic [3:0]       len;
    logic [7:0]       tgt;
    logic             st, ab, dv, d;
    logic             e_hit;
    logic [7:0]       e_cnt;
    logic             e_busy, e_done, e_rdy;
  } vec_t;

  vec_t tbl[9];

  int hi_cycles, rises;
  logic prev_hit;
  logic [7:0] seq8;
  logic [11:0] seq12;

  initial begin
    // start, then 1,0,1,1,0 with default config; hit is 2 cycles wide
    // beginning one cycle after the last bit
    tbl[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

    do_reset();
    chk("rst_hit", hit_pulse, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", cfg_ready, 1);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].cv, tbl[i].pat, tbl[i].len[LEN_W-1:0], tbl[i].tgt,
            tbl[i].st, tbl[i].ab, tbl[i].dv, tbl[i].d);
      step();
      chk($sformatf("vec%0d_hit", i), hit_pulse, tbl[i].e_hit);
      chk($sformatf("vec%0d_cnt", i), match_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("vec%0d_rdy", i), cfg_ready, tbl[i].e_rdy);
    end

    // overlapping stream 1,0,1,1,0,1,1,0
    do_abort();
    do_start();
    seq8 = 8'b10110110;
    for (int i = 7; i >= 0; i--) bit_in(1, seq8[i]);
    repeat (3) idle();
`ifdef SEQ_DET_NO_OVERLAP_EN
    chk("overlap_cnt", match_cnt, 1);
`else
    chk("overlap_cnt", match_cnt, 2);
`endif
    do_start();  // ignored while running: count not cleared
`ifdef SEQ_DET_NO_OVERLAP_EN
    chk("start_in_run_cnt", match_cnt, 1);
`else
    chk("start_in_run_cnt", match_cnt, 2);
`endif
    chk("start_in_run_busy", busy, 1);

    // target of 2 with pattern 0011
    do_abort();
    do_cfg(8'b0011, 4, 2);
    do_start();
    chk("tgt_busy", busy, 1);
    seq12 = 12'b001100110011;
    for (int i = 11; i >= 0; i--) bit_in(1, seq12[i]);
    repeat (3) idle();
    chk("tgt_done", done, 1);
    chk("tgt_busy_lo", busy, 0);
    chk("tgt_cnt", match_cnt, 2);
    chk("tgt_rdy", cfg_ready, 1);

    // din_valid toggling: bits on invalid cycles are ignored
    do_cfg(8'b10110, 5, 0);
    do_start();
    bit_in(1, 1); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0);
    bit_in(1, 1); bit_in(0, 0); bit_in(1, 1); bit_in(1, 0);
    repeat (3) idle();
    chk("toggle_cnt", match_cnt, 1);

    // single-bit pattern: six 1s give one 7-cycle continuous pulse
    do_abort();
    do_cfg(8'b1, 1, 0);
    do_start();
    hi_cycles = 0; rises = 0; prev_hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) bit_in(1, 1); else idle();
      if (hit_pulse) hi_cycles++;
      if (hit_pulse && !prev_hit) rises++;
      prev_hit = hit_pulse;
    end
    chk("stretch_cycles", hi_cycles, 7);
    chk("stretch_rises", rises, 1);
    chk("stretch_cnt", match_cnt, 6);
    bit_in(1, 1);
    idle();
    chk("pre_abort_hit", hit_pulse, 1);
    chk("pre_abort_cnt", match_cnt, 7);
    do_abort();
    chk("abort_hit", hit_pulse, 0);
    chk("abort_cnt_held", match_cnt, 7);
    chk("abort_busy", busy, 0);

    // start+abort in IDLE stays IDLE; zero length cannot start
    drive(0, 0, 0, 0, 1, 1, 0, 0); step();
    chk("st_ab_busy", busy, 0);
    do_cfg(8'b1, 0, 0);
    do_start();
    chk("len0_busy", busy, 0);
    chk("len0_rdy", cfg_ready, 1);

    // abort mid-stream after 1,0,1
    do_cfg(8'b10110, 5, 0);
    do_start();
    bit_in(1, 1); bit_in(1, 0); bit_in(1, 1);
    do_abort();
    chk("mid_abort_busy", busy, 0);
    chk("mid_abort_hit", hit_pulse, 0);
    chk("mid_abort_cnt", match_cnt, 0);

    // reset mid-run restores outputs and default config
    do_cfg(8'b1, 1, 0);
    do_start();
    bit_in(1, 1); bit_in(1, 1);
    chk("pre_rst_cnt", match_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hit", hit_pulse, 0);
    chk("async_rst_cnt", match_cnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rdy", cfg_ready, 1);
    do_reset();
    do_start();
    seq8 = 8'b10110000;
    for (int i = 7; i >= 3; i--) bit_in(1, seq8[i]);
    repeat (3) idle();
    chk("rst_cfg_cnt", match_cnt, 1);

    // randomized run against the model
    do_reset();
    mchk = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic [LEN_W-1:0] l;
      l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 9)) : LEN_W'($urandom_range(1, 3));
      drive(($urandom_range(0, 99) < 8), MAX_LEN'($urandom), l, CNT_W'($urandom_range(0, 4)),
            ($urandom_range(0, 99) < 6), ($urandom_range(0, 199) < 3),
            ($urandom_range(0, 3) != 0), 1'($urandom));
      step();
    end
    mchk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
